matrix_scan_ctrl: RTL
=====================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameter ACTIVE_CYC, default 1000: clock cycles a column is driven; legal range 1..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 8: clock cycles of blanking before each column; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port run, input, 1 bit: 1 = scanning permitted.
REQ-006 SHALL have ports wr_valid, input, 1 bit; wr_col, input, 3 bits; wr_data, input, 3 bits: shadow-buffer write request, target column, pattern index.
REQ-007 SHALL have port wr_ready, output, 1 bit: shadow buffer accepts writes.
REQ-008 SHALL have port commit, input, 1 bit: request shadow-to-active copy.
REQ-009 SHALL have ports commit_done, frame_done and wr_err, outputs, 1 bit each: single-cycle pulses.
REQ-010 SHALL have port sel, output, 3 bits: pattern index to the column decoder.
REQ-011 SHALL have port enable, output, 1 bit: column decoder enable, active-high.
REQ-012 SHALL have port col_n, output, 5 bits: column drivers, active-low, bit i = column i.

Function
REQ-013 SHALL implement FSM states IDLE, BLANK and ACTIVE, plus a 3-bit column index col (0..4) and a 16-bit cycle counter.
REQ-014 IDLE: enable=0, col_n=5'b11111, col=0; run=1 -> BLANK next cycle with counter=0.
REQ-015 BLANK: enable=0, col_n=5'b11111, sel=active[col]; after exactly BLANK_CYC cycles -> ACTIVE.
REQ-016 ACTIVE: enable=1, col_n[col]=0 with all other bits 1, sel=active[col]; after exactly ACTIVE_CYC cycles -> BLANK with col+1.
REQ-017 Column wrap: col 4 -> 0; frame_done SHALL pulse on the cycle BLANK for column 0 is entered from column 4.
REQ-018 Scan period SHALL be 5*(BLANK_CYC+ACTIVE_CYC) cycles; no two col_n bits SHALL ever be 0 at once.
REQ-019 run=0 in BLANK or ACTIVE SHALL force IDLE next cycle, col=0, with no frame_done.
REQ-020 Write handshake: write occurs when wr_valid and wr_ready are 1 on a clock edge; shadow[wr_col] <= wr_data.
REQ-021 wr_col >= 5 with wr_valid=1 and wr_ready=1: no write; wr_err pulses the next cycle.
REQ-022 commit=1 SHALL set commit_pending; wr_ready = NOT commit_pending.
REQ-023 While commit_pending, active <= shadow (all 5 entries) SHALL occur on the frame_done cycle, or on the next cycle while in IDLE; commit_pending clears and commit_done pulses on the same edge.
REQ-024 commit while commit_pending=1 SHALL be ignored; a single commit_done results.
REQ-025 commit on the same cycle as frame_done SHALL take effect at the following frame boundary, not the current one.
REQ-026 The active buffer SHALL change only at a frame boundary or in IDLE; sel is tear-free within a frame.
REQ-027 All outputs SHALL be registered; no combinational path from an input to an output.

Reset
REQ-028 reset=1 SHALL immediately force: state IDLE, col=0, counter=0, enable=0, col_n=5'b11111, sel=0, wr_ready=1, all pulses 0, commit_pending=0.
REQ-029 reset SHALL clear all shadow and active entries to 0.
REQ-030 reset asserted mid-ACTIVE SHALL blank the columns asynchronously, without waiting for a clock.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=0, BLANK=1, ACTIVE=2), NCOL=5 and the default cycle constants.
REQ-032 The 5x3 shadow/active buffer pair with commit logic SHALL be one sub-module, scan_buf; the FSM and counters stay in the top module.
REQ-033 The existing column decoder SHALL be instantiated outside this block, driven by sel and enable.

Verification (ACTIVE_CYC=4, BLANK_CYC=2)
REQ-034 Reset, run=1, no writes -> col_n sequence 11110,11101,11011,10111,01111, each for 4 cycles with 2 blank cycles between; frame_done every 30 cycles; sel=0.
REQ-035 Write columns 0..4 = 1,2,3,4,5, then commit mid-frame -> sel is unchanged until frame_done, then sel per column = 1,2,3,4,5; one commit_done pulse.
REQ-036 wr_valid with wr_col=6 -> shadow unchanged, one wr_err pulse; wr_valid after commit and before commit_done -> wr_ready=0, no write.
REQ-037 commit on the frame_done cycle -> copy and commit_done occur exactly 30 cycles later.
REQ-038 run=0 during column 2 ACTIVE -> next cycle enable=0, col_n=11111, no frame_done; run=1 again -> scan restarts at column 0 after 2 blank cycles.
REQ-039 reset pulsed mid-ACTIVE between clock edges -> col_n=11111 and enable=0 before the next edge; buffers read 0.

Source files
------------

// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared types and constants for the LED matrix column scanner.
package matrix_scan_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int NCOL           = 5;
    localparam int COLW           = 3;
    localparam int PATW           = 3;
    localparam int DEF_ACTIVE_CYC = 1000;
    localparam int DEF_BLANK_CYC  = 8;
endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Control/write/drive bundle between the scanner and its host.
interface matrix_scan_ctrl_if
    import matrix_scan_ctrl_pkg::*;
;
    logic            run;
    logic            wr_valid;
    logic [COLW-1:0] wr_col;
    logic [PATW-1:0] wr_data;
    logic            wr_ready;
    logic            commit;
    logic            commit_done;
    logic            frame_done;
    logic            wr_err;
    logic [PATW-1:0] sel;
    logic            enable;
    logic [NCOL-1:0] col_n;

    modport master (
        output run, wr_valid, wr_col, wr_data, commit,
        input  wr_ready, commit_done, frame_done, wr_err, sel, enable, col_n
    );
    modport slave (
        input  run, wr_valid, wr_col, wr_data, commit,
        output wr_ready, commit_done, frame_done, wr_err, sel, enable, col_n
    );
endinterface

// File: rtl/matrix_scan_ctrl_scan_buf.sv
// Shadow/active pattern buffers; shadow is copied to active only at a frame boundary or while idle.
module scan_buf
    import matrix_scan_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    input  logic [COLW-1:0] wr_col,
    input  logic [PATW-1:0] wr_data,
    input  logic            commit,
    input  logic            frame_done,
    input  logic            idle,
    input  logic [COLW-1:0] rd_col,
    output logic            wr_ready,
    output logic            wr_err,
    output logic            commit_done,
    output logic [PATW-1:0] sel
);
    logic [NCOL-1:0][PATW-1:0] shadow, active;
    logic pending, copy, wr_fire;

    // frame_done is the registered pulse, so a commit seen on that same edge waits a full frame
    assign copy    = pending && (frame_done || idle);
    assign wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            wr_ready    <= 1'b1;
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
            sel         <= '0;
        end else begin
            if (copy)
                active <= shadow;
            if (wr_fire && wr_col < COLW'(NCOL))
                shadow[wr_col] <= wr_data;
            wr_err      <= wr_fire && (wr_col >= COLW'(NCOL));
            commit_done <= copy;
            pending     <= copy ? 1'b0 : (pending | commit);
            wr_ready    <= copy ? 1'b1 : ~(pending | commit);
            // sel tracks the post-edge active contents for the post-edge column
            sel         <= copy ? shadow[rd_col] : active[rd_col];
        end
    end
endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column scan sequencer: blank, then drive each of NCOL columns in turn, with registered drive outputs.
module matrix_scan_ctrl
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int ACTIVE_CYC = DEF_ACTIVE_CYC,
    parameter int BLANK_CYC  = DEF_BLANK_CYC
) (
    input  logic               clk,
    input  logic               reset,
    matrix_scan_ctrl_if.slave  bus
);
    state_t          state, state_nxt;
    logic [COLW-1:0] col, col_nxt;
    logic [15:0]     cnt, cnt_nxt;
    logic            frame_nxt, frame_q, enable_q;
    logic [NCOL-1:0] col_n_nxt, col_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            col      <= '0;
            cnt      <= '0;
            frame_q  <= 1'b0;
            enable_q <= 1'b0;
            col_n_q  <= '1;
        end else begin
            state    <= state_nxt;
            col      <= col_nxt;
            cnt      <= cnt_nxt;
            frame_q  <= frame_nxt;
            enable_q <= (state_nxt == ACTIVE);
            col_n_q  <= col_n_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        cnt_nxt   = cnt;
        frame_nxt = 1'b0;
        case (state)
            IDLE: begin
                col_nxt = '0;
                cnt_nxt = '0;
                if (bus.run) state_nxt = BLANK;
            end
            BLANK: begin
                if (cnt == 16'(BLANK_CYC - 1)) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ACTIVE: begin
                if (cnt == 16'(ACTIVE_CYC - 1)) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    if (col == COLW'(NCOL - 1)) begin
                        col_nxt   = '0;
                        frame_nxt = 1'b1;
                    end else begin
                        col_nxt = col + COLW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // dropping run abandons the frame without a boundary pulse
        if (state != IDLE && !bus.run) begin
            state_nxt = IDLE;
            col_nxt   = '0;
            cnt_nxt   = '0;
            frame_nxt = 1'b0;
        end
    end

    always_comb begin
        col_n_nxt = '1;
        if (state_nxt == ACTIVE) col_n_nxt[col_nxt] = 1'b0;
    end

    scan_buf u_buf (
        .clk         (clk),
        .rst         (reset),
        .wr_valid    (bus.wr_valid),
        .wr_col      (bus.wr_col),
        .wr_data     (bus.wr_data),
        .commit      (bus.commit),
        .frame_done  (frame_q),
        .idle        (state == IDLE),
        .rd_col      (col_nxt),
        .wr_ready    (bus.wr_ready),
        .wr_err      (bus.wr_err),
        .commit_done (bus.commit_done),
        .sel         (bus.sel)
    );

    assign bus.enable     = enable_q;
    assign bus.col_n      = col_n_q;
    assign bus.frame_done = frame_q;
endmodule
